// File: rtl/pc_pkg.sv
// Shared state encoding, action encoding and target extension for the fetch-address generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // Winning per-cycle action, listed from highest to lowest priority.
  localparam logic [1:0] ACT_BRANCH = 2'd0;
  localparam logic [1:0] ACT_CALL   = 2'd1;
  localparam logic [1:0] ACT_RET    = 2'd2;
  localparam logic [1:0] ACT_CTRL   = 2'd3;

  localparam int ZEXT_MAX_W = 64;

  function automatic logic [ZEXT_MAX_W-1:0] zext_target(input logic [ZEXT_MAX_W-1:0] tgt,
                                                       input int tgt_w);
    logic [ZEXT_MAX_W-1:0] mask;
    if (tgt_w >= ZEXT_MAX_W) mask = '1;
    else                     mask = (ZEXT_MAX_W'(1) << tgt_w) - ZEXT_MAX_W'(1);
    return tgt & mask;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pop_data is the current top, updates on the clock after push/pop.
// A push when full overwrites the oldest entry; push and pop are never asserted together.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] top_q;  // next slot to write; the top entry sits just below it
  logic [PW:0]   cnt_q;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign pop_data = mem_q[top_q - PTR_ONE];

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[top_q] <= push_data;
      top_q        <= top_q + PTR_ONE;
      if (!full) cnt_q <= cnt_q + CNT_ONE;
    end else if (pop && !empty) begin
      top_q <= top_q - PTR_ONE;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-address generator: redirects land next cycle, advance only on pc_valid && pc_ready (address held otherwise).
// Return-address stack for call/ret is built only when PC_RAS_EN is defined.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              TGT_W      = 16,
  parameter int              STEP       = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_en,
  input  logic [TGT_W-1:0]  branch_target,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic              halt,
  input  logic              resume,
  input  logic              pc_ready,
  output logic [ADDR_W-1:0] ins_address,
  output logic              pc_valid,
  output logic              ras_underflow,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  pc_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              uf_q;

  logic [ADDR_W-1:0] tgt_addr;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] redir_addr;
  logic [1:0]        act;
  logic              ret_miss;

  assign tgt_addr = ADDR_W'(zext_target(ZEXT_MAX_W'(branch_target), TGT_W));
  assign seq_addr = addr_q + STEP_A;

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full_unused;

  // A return only redirects when there is something to pop.
  always_comb begin
    act = ACT_CTRL;
    if (branch_en)                  act = ACT_BRANCH;
    else if (call_en)               act = ACT_CALL;
    else if (ret_en && !ras_empty)  act = ACT_RET;
  end

  assign ret_miss   = !branch_en && !call_en && ret_en && ras_empty;
  assign redir_addr = (act == ACT_RET) ? ras_top : tgt_addr;

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (!reset && (act == ACT_CALL)),
    .pop       (!reset && (act == ACT_RET)),
    .push_data (seq_addr),
    .pop_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`else
  logic ret_unused;

  assign ret_unused = ret_en;
  assign act        = (branch_en || call_en) ? ACT_BRANCH : ACT_CTRL;
  assign ret_miss   = 1'b0;
  assign redir_addr = tgt_addr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      addr_q  <= RESET_ADDR;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      uf_q <= ret_miss;
      if (act != ACT_CTRL) addr_q <= redir_addr;
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (act == ACT_CTRL) begin
            if (halt) begin
              state_q <= HALTED;
              valid_q <= 1'b0;
            end else if (pc_ready) begin
              addr_q <= seq_addr;
            end
          end
        end
        HALTED: begin
          if (act == ACT_CTRL && resume) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ins_address   = addr_q;
  assign pc_valid      = valid_q;
  assign ras_underflow = uf_q;
  assign state_o       = state_q;

endmodule
